// File: rtl/and_isw_if.sv
// Operand/randomness/result bundle with valid/ready handshakes for the ISW AND gadget.
interface and_isw_if #(
    parameter int unsigned ORDER = 3,
    parameter int unsigned WIDTH = 1
);
    localparam int unsigned N  = ORDER + 1;
    localparam int unsigned NR = N * (N - 1) / 2;

    logic                  in_valid;
    logic                  in_ready;
    logic [N*WIDTH-1:0]    port_a;
    logic [N*WIDTH-1:0]    port_b;
    logic [NR*WIDTH-1:0]   port_r;
    logic                  out_valid;
    logic                  out_ready;
    logic [N*WIDTH-1:0]    port_c;

    modport master (
        output in_valid, port_a, port_b, port_r, out_ready,
        input  in_ready, out_valid, port_c
    );

    modport slave (
        input  in_valid, port_a, port_b, port_r, out_ready,
        output in_ready, out_valid, port_c
    );
endinterface

// File: rtl/and_isw_pipe.sv
// d-th order masked AND (ISW), three register levels with cross-products kept
// apart until registered; valid/ready pipeline with full stall and flush.
module and_isw_pipe #(
    parameter int unsigned ORDER = 3,
    parameter int unsigned WIDTH = 1
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      flush,
    and_isw_if.slave  bus
);
    localparam int unsigned N  = ORDER + 1;
    localparam int unsigned NR = N * (N - 1) / 2;
    localparam int unsigned NW = $clog2(N);
    localparam int unsigned KW = (NR > 1) ? $clog2(NR) : 1;

    typedef logic [N-1:0][WIDTH-1:0]  shares_t;
    typedef logic [NR-1:0][WIDTH-1:0] rand_t;

    // Randomness word index for share pair (i,j), i<j.
    function automatic logic [KW-1:0] pair_idx(input int unsigned i, input int unsigned j);
        return KW'(j * (j - 1) / 2 + i);
    endfunction

    shares_t a_w;
    shares_t b_w;
    rand_t   r_w;

    assign a_w = bus.port_a;
    assign b_w = bus.port_b;
    assign r_w = bus.port_r;

    logic    adv;
    logic    v1, v2, v3;

    rand_t   zz_d, zz1_d;
    shares_t p_d, c_d;

    rand_t   s1_zz, s1_zz1, s1_r;
    shares_t s1_p;
    rand_t   s2_z, s2_r;
    shares_t s2_p;
    shares_t s3_c;

    assign adv           = !v3 || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = v3;
    assign bus.port_c    = s3_c;

    // Stage-1 products; the two cross terms of a pair stay in separate registers.
    always_comb begin
        zz_d  = '0;
        zz1_d = '0;
        p_d   = '0;
        for (int unsigned j = 1; j < N; j++) begin
            for (int unsigned i = 0; i < j; i++) begin
                zz_d[pair_idx(i, j)]  = r_w[pair_idx(i, j)] ^ (a_w[NW'(i)] & b_w[NW'(j)]);
                zz1_d[pair_idx(i, j)] = a_w[NW'(j)] & b_w[NW'(i)];
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            p_d[NW'(i)] = a_w[NW'(i)] & b_w[NW'(i)];
        end
    end

    // Output recombination: r goes to the lower share of a pair, z to the higher.
    always_comb begin
        c_d = s2_p;
        for (int unsigned j = 1; j < N; j++) begin
            for (int unsigned i = 0; i < j; i++) begin
                c_d[NW'(i)] = c_d[NW'(i)] ^ s2_r[pair_idx(i, j)];
                c_d[NW'(j)] = c_d[NW'(j)] ^ s2_z[pair_idx(i, j)];
            end
        end
    end

    // Data path loads on every advance; contents are don't-care behind a clear valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_zz  <= '0;
            s1_zz1 <= '0;
            s1_r   <= '0;
            s1_p   <= '0;
            s2_z   <= '0;
            s2_r   <= '0;
            s2_p   <= '0;
            s3_c   <= '0;
        end else if (adv) begin
            s1_zz  <= zz_d;
            s1_zz1 <= zz1_d;
            s1_r   <= r_w;
            s1_p   <= p_d;
            s2_z   <= s1_zz ^ s1_zz1;
            s2_r   <= s1_r;
            s2_p   <= s1_p;
            s3_c   <= c_d;
        end
    end

    // Valid chain; flush drops everything in flight, including a beat offered with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (adv) begin
            v1 <= bus.in_valid;
            v2 <= v1;
            v3 <= v2;
        end
    end
endmodule

// File: tb/tb_and_isw_pipe.sv
// Scoreboard bench for and_isw_pipe: directed ORDER=3/WIDTH=8 vectors plus
// random handshake sweeps over ORDER=1..7 at WIDTH=4.
module tb_and_isw_pipe;
    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic sw_flush = 1'b0;
    bit   sweep_go = 1'b0;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    typedef struct {
        bit          exact;
        logic [31:0] shares;
        logic [7:0]  xr;
    } exp_t;

    exp_t sb[$];

    and_isw_if #(.ORDER(3), .WIDTH(8)) bus ();

    and_isw_pipe #(.ORDER(3), .WIDTH(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        n_vec++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    function automatic logic [7:0] fold8(input logic [31:0] v);
        return v[7:0] ^ v[15:8] ^ v[23:16] ^ v[31:24];
    endfunction

    function automatic logic [31:0] mask8(input logic [7:0] v);
        logic [7:0] s1, s2, s3;
        s1 = 8'($urandom);
        s2 = 8'($urandom);
        s3 = 8'($urandom);
        return {s3, s2, s1, v ^ s1 ^ s2 ^ s3};
    endfunction

    function automatic exp_t mk(input bit exact, input logic [31:0] sh, input logic [7:0] xr);
        exp_t e;
        e.exact  = exact;
        e.shares = sh;
        e.xr     = xr;
        return e;
    endfunction

    // Offers one beat, waits (bounded) for acceptance, queues its expectation.
    task automatic send_raw(input logic [31:0] a, input logic [31:0] b,
                            input logic [47:0] r, input exp_t e);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.port_a   = a;
        bus.port_b   = b;
        bus.port_r   = r;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (bus.in_ready && !flush) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            sb.push_back(e);
            @(posedge clk);
            #1;
        end else begin
            chk("accept_timeout", 64'(0), 64'(1));
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_val(input logic [7:0] av, input logic [7:0] bv);
        send_raw(mask8(av), mask8(bv), {16'($urandom), 32'($urandom)}, mk(1'b0, 32'h0, av & bv));
    endtask

    task automatic send_exact(input logic [31:0] a, input logic [31:0] b,
                              input logic [47:0] r, input logic [31:0] sh);
        send_raw(a, b, r, mk(1'b1, sh, fold8(sh)));
    endtask

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_left", 64'(sb.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    // Main monitor: pops and compares whenever a result is handed over.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL spurious_out: got %h, required no output", bus.port_c);
            end else begin
                e = sb.pop_front();
                if (e.exact) chk("c_shares", 64'(bus.port_c), 64'(e.shares));
                chk("c_xor", 64'(fold8(bus.port_c)), 64'(e.xr));
            end
        end
    end

    // Random handshake sweeps, one pipeline per order.
    for (genvar go = 1; go <= 7; go++) begin : g_sw
        localparam int SN  = go + 1;
        localparam int SNR = SN * (SN - 1) / 2;

        and_isw_if #(.ORDER(go), .WIDTH(4)) sbus ();

        and_isw_pipe #(.ORDER(go), .WIDTH(4)) u_dut (
            .clk   (clk),
            .reset (reset),
            .flush (sw_flush),
            .bus   (sbus)
        );

        logic [3:0] q[$];
        bit done = 1'b0;

        initial begin
            logic [3:0] xa, xb;
            int acc, cyc;
            sbus.in_valid  = 1'b0;
            sbus.out_ready = 1'b1;
            sbus.port_a    = '0;
            sbus.port_b    = '0;
            sbus.port_r    = '0;
            wait (sweep_go);
            @(posedge clk);
            #1;
            acc = 0;
            cyc = 0;
            while (acc < 1000 && cyc < 20000) begin
                xa = '0;
                xb = '0;
                for (int s = 0; s < SN; s++) begin
                    sbus.port_a[s*4 +: 4] = 4'($urandom);
                    sbus.port_b[s*4 +: 4] = 4'($urandom);
                    xa ^= sbus.port_a[s*4 +: 4];
                    xb ^= sbus.port_b[s*4 +: 4];
                end
                for (int k = 0; k < SNR; k++) sbus.port_r[k*4 +: 4] = 4'($urandom);
                sbus.in_valid  = ($urandom_range(3) != 0);
                sbus.out_ready = ($urandom_range(1) != 0);
                @(negedge clk);
                if (sbus.in_valid && sbus.in_ready) begin
                    q.push_back(xa & xb);
                    acc++;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
            sbus.in_valid  = 1'b0;
            sbus.out_ready = 1'b1;
            for (int t = 0; t < 50 && q.size() != 0; t++) @(negedge clk);
            chk($sformatf("sweep%0d_accepted", go), 64'(acc), 64'(1000));
            chk($sformatf("sweep%0d_left", go), 64'(q.size()), 64'(0));
            done = 1'b1;
        end

        always @(negedge clk) begin : smon
            logic [3:0] gx, ex;
            if (reset && sbus.out_valid && sbus.out_ready) begin
                gx = '0;
                for (int s = 0; s < SN; s++) gx ^= sbus.port_c[s*4 +: 4];
                if (q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL sweep%0d_spurious: got %h, required no output", go, gx);
                end else begin
                    ex = q.pop_front();
                    chk($sformatf("sweep%0d_xor", go), 64'(gx), 64'(ex));
                end
            end
        end
    end

    logic [7:0] bp_a [8] = '{8'hFF, 8'h0F, 8'hAA, 8'h33, 8'hC3, 8'h81, 8'h7E, 8'h00};
    logic [7:0] bp_b [8] = '{8'h5A, 8'hFF, 8'h55, 8'h3C, 8'hF0, 8'hFF, 8'h18, 8'hFF};

    initial begin
        logic [3:0] pv;
        int lat;
        bit all_done;

        reset          = 1'b0;
        flush          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.port_a     = '0;
        bus.port_b     = '0;
        bus.port_r     = '0;
        bus.out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(bus.out_valid), 64'(0));
        chk("reset_in_ready", 64'(bus.in_ready), 64'(1));
        chk("reset_port_c", 64'(bus.port_c), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // All 2-bit (a,b) combinations, back to back, with latency/continuity watch.
        fork
            begin
                for (int p = 0; p < 16; p++) begin
                    pv = 4'(p);
                    send_val({4{pv[3:2]}}, {4{pv[1:0]}});
                end
            end
            begin
                for (int t = 0; t < 20; t++) begin
                    @(negedge clk);
                    if (bus.in_valid && bus.in_ready) break;
                end
                for (lat = 1; lat <= 10; lat++) begin
                    @(negedge clk);
                    if (bus.out_valid) break;
                end
                chk("first_latency", 64'(lat), 64'(3));
                repeat (15) begin
                    @(negedge clk);
                    chk("stream_continuous", 64'(bus.out_valid), 64'(1));
                end
            end
        join
        drain();

        // Share placement and randomness-index mapping, hand-computed.
        send_exact(32'h0000_00FF, 32'h0000_00FF, 48'h0,               32'h0000_00FF);
        send_exact(32'h0000_00FF, 32'h0000_00FF, 48'hA5_0000_0000_00, 32'hA5A5_00FF);
        send_exact(32'h0000_00FF, 32'h0000_00FF, 48'h0000_0000_003C, 32'h0000_3CC3);
        send_exact(32'h0000_00FF, 32'h0000_00FF, 48'h0000_5A00_0000, 32'h5A00_00A5);
        send_exact(32'h0000_00FF, 32'h0000_00FF, 48'h0000_0077_0000, 32'h0077_77FF);
        send_exact(32'h0000_FF00, 32'h0000_FF00, 48'h0,               32'h0000_FF00);
        send_exact(32'h0000_00F0, 32'h0000_3C00, 48'h0,               32'h0000_3000);
        send_exact(32'h0000_F000, 32'h0000_003C, 48'h0,               32'h0000_3000);
        drain();

        // Backpressure: consumer stalls for five cycles mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++) send_val(bp_a[i], bp_b[i]);
            end
            begin
                logic [31:0] held;
                repeat (5) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                @(negedge clk);
                held = bus.port_c;
                chk("stall_out_valid", 64'(bus.out_valid), 64'(1));
                chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_port_c_stable", 64'(bus.port_c), 64'(held));
                    chk("stall_out_valid", 64'(bus.out_valid), 64'(1));
                    chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Flush: A leaves during the flush cycle, B and C are dropped.
        send_val(8'hF0, 8'hCC);
        send_val(8'h0F, 8'hCC);
        send_val(8'hFF, 8'h99);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_pending", 64'(sb.size()), 64'(2));
        while (sb.size() > 0) void'(sb.pop_back());
        repeat (4) begin
            @(negedge clk);
            chk("flush_out_valid", 64'(bus.out_valid), 64'(0));
        end
        @(posedge clk);
        #1;
        send_val(8'hE7, 8'h7E);
        drain();

        // Asynchronous reset with three beats in flight.
        send_val(8'h12, 8'hFF);
        send_val(8'h34, 8'hFF);
        send_val(8'h56, 8'hFF);
        reset = 1'b0;
        #1;
        chk("midreset_out_valid", 64'(bus.out_valid), 64'(0));
        chk("midreset_port_c", 64'(bus.port_c), 64'(0));
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("postreset_out_valid", 64'(bus.out_valid), 64'(0));
        end
        @(posedge clk);
        #1;
        send_val(8'hA5, 8'h3C);
        drain();

        sweep_go = 1'b1;
        all_done = 1'b0;
        for (int t = 0; t < 30000; t++) begin
            @(negedge clk);
            all_done = g_sw[1].done && g_sw[2].done && g_sw[3].done && g_sw[4].done &&
                       g_sw[5].done && g_sw[6].done && g_sw[7].done;
            if (all_done) break;
        end
        chk("sweep_finished", 64'(all_done), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
